// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared state encoding and default dwell for the mux scan sequencer
package mux_scan_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
  localparam int DWELL_DEF = 2;
endpackage

// File: rtl/multiplexer_4_to_1.sv
// multiplexer_4_to_1: combinational 4-to-1 mux selected by S1:S0
module multiplexer_4_to_1 (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic S0,
  input  logic S1,
  output logic Y
);
  assign Y = S1 ? (S0 ? D : C) : (S0 ? B : A);
endmodule

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// dwell_counter: loadable down-counter that stops at zero and flags it
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = (cnt == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps mux selects 0..3, samples Y after a dwell, publishes a 4-bit scan word
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy,
  output logic       changed
);
  state_t     state, next;
  logic [1:0] sel;
  logic [3:0] shadow;
  logic       load, zero, valid_d, busy_d, cap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = abort                ? IDLE :
           (state == IDLE)      ? (start ? SETTLE : IDLE) :
           (state == SETTLE)    ? (zero ? CAPTURE : SETTLE) :
           (state == CAPTURE)   ? ((sel == 2'd3) ? DONE : SETTLE) :
                                  (continuous ? SETTLE : IDLE);
  end
  always_comb begin
    load    = (next == SETTLE) && (state != SETTLE);
    valid_d = (next == DONE);
    busy_d  = (next != IDLE);
    cap     = (state == CAPTURE) && !abort;
  end
  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CNT_W'(DWELL - 1)),
    .en       (state == SETTLE),
    .zero     (zero)
  );
  // sel only advances out of CAPTURE; every return to channel 0 goes through IDLE, DONE or abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel     <= 2'd0;
      shadow  <= 4'd0;
      sample  <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      changed <= 1'b0;
    end else begin
      valid <= valid_d;
      busy  <= busy_d;
      sel   <= (abort || state == IDLE || state == DONE) ? 2'd0 :
               (cap && sel != 2'd3) ? sel + 2'd1 : sel;
      if (cap) shadow[sel] <= Y;
      if (cap && sel == 2'd3) begin
        sample  <= {Y, shadow[2:0]};
        changed <= ({Y, shadow[2:0]} != sample);
      end
    end
  assign S0 = sel[0];
  assign S1 = sel[1];
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream control stage for the 4-to-1 multiplexer.
- Drives the mux select lines S1:S0 through channels 0..3 in order.
- Holds each select for a programmable settle time, then samples the mux output Y.
- After the fourth channel, publishes all four samples as one 4-bit word with a valid pulse.
- Runs single-shot or continuous scans, with abort and change detection.

Parameters:
DWELL, 2, settle cycles per channel before Y is sampled; legal range 1..255.
CNT_W, 8, width of the dwell counter; must satisfy 2**CNT_W > DWELL.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level; sampled only in IDLE; begins a scan
continuous  input  1  when 1, a new scan starts immediately after DONE
abort  input  1  synchronous abort; returns to IDLE
Y  input  1  mux output being scanned
S0  output  1  select LSB, driven to mux
S1  output  1  select MSB, driven to mux
sample  output  4  last published scan; bit n = Y captured with select n
valid  output  1  one-cycle pulse when sample updates
busy  output  1  high in every state except IDLE
changed  output  1  qualifies valid; 1 if new sample differs from previous published sample

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; sel=0 (so S1=0, S0=0); dwell counter=0; shadow=0; sample=4'b0000; valid=0; busy=0; changed=0.
- Timing: clocked flops only; all outputs are registered. S1:S0 equal the sel register, so the mux sees a new select in the cycle after sel updates.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE:
  - If start=1 and abort=0: sel<=0, cnt<=DWELL-1, go to SETTLE.
  - Otherwise hold.
- SETTLE:
  - If cnt!=0: cnt<=cnt-1 and stay.
  - If cnt==0: go to CAPTURE.
  - Result: exactly DWELL cycles per channel in SETTLE.
- CAPTURE (one cycle): shadow[sel]<=Y.
  - If sel!=3: sel<=sel+1, cnt<=DWELL-1, go to SETTLE.
  - If sel==3: sample<={Y,shadow[2:0]}; changed<=({Y,shadow[2:0]}!=sample); go to DONE.
- DONE (one cycle): valid=1.
  - If continuous=1: sel<=0, cnt<=DWELL-1, go to SETTLE.
  - Else: sel<=0, go to IDLE.
- Latency: valid is high in the cycle that begins 4*(DWELL+1) rising edges after the edge that sampled start. DWELL=2 gives 12. In continuous mode valid repeats every 4*(DWELL+1)+1 cycles.
- changed:
  - Updated only on entry to DONE; holds its value otherwise.
  - First scan after reset compares against 4'b0000.
- start while busy: ignored; it does not queue or restart.
- abort:
  - Any state to IDLE on the next edge; sel<=0.
  - valid stays 0; sample and changed keep their old values; shadow is not cleared.
  - abort has priority over start in IDLE and over DONE→SETTLE.
- continuous: sampled only in DONE. Deasserting it mid-scan finishes the current scan, then the block idles.
- Wrap-around: sel never exceeds 3; 3→0 occurs only via DONE, abort or reset.
- Reset mid-scan: immediate return to reset values; a partially captured scan is discarded.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2, DONE=2'd3) and the default DWELL value.
- One sub-module, dwell_counter:
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Parameterised by CNT_W.
- FSM, select register and capture logic stay in the top level.
- Bench instantiates this block driving multiplexer_4_to_1, with A..D as bench regs.

Test Plan:
- Single scan, DWELL=2, A=1 B=0 C=1 D=0, continuous=0, pulse start → S1:S0 steps 00,01,10,11 (3 cycles each); valid high for one cycle 12 cycles after start; sample=4'b0101; changed=1; busy falls after DONE.
- Repeat the same inputs → sample=4'b0101, changed=0. Then set D=1 → sample=4'b1101, changed=1.
- Continuous=1, A..D=0,0,0,1 → valid pulses every 13 cycles with sample=4'b1000. Drop continuous mid-scan → exactly one more valid pulse, then IDLE.
- Abort asserted in SETTLE of channel 2 → IDLE next cycle, S1:S0=00, no valid, sample keeps its prior value. Start and abort together in IDLE → stays IDLE.
- Start re-pulsed while busy → scan timing unchanged; one valid per scan.
- rst_n low asynchronously mid-CAPTURE (between clock edges) → all outputs 0 immediately. After release, the next scan behaves as the first scan after reset (changed vs 4'b0000).
